sipo_deser_8bit: RTL and testbench

SIPO_DESER_8BIT -- requirements
Module: sipo_deser_8bit

---
 rtl/piso_regs_pkg.sv | 19 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/sipo_deser_8bit.sv | 86 ++++++++
 tb/tb_sipo_deser_8bit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/piso_regs_pkg.sv
// Shared defaults and helpers for the serial-in/parallel-out deserializer and its output buffer.
package piso_regs_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned BIT_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_PUSH = 2'b10,
    FIFO_POP  = 2'b01,
    FIFO_SWAP = 2'b11
  } fifo_op_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO; a push at full is accepted only alongside a pop.
module sync_fifo
  import piso_regs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  fifo_op_e         w_op;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_comb begin
    w_op = FIFO_HOLD;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_op = FIFO_PUSH;
      2'b01:   w_op = FIFO_POP;
      2'b11:   w_op = FIFO_SWAP;
      default: w_op = FIFO_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // At full with a pop, wptr==rptr: the head is read out before its slot is overwritten.
      if (w_push_ok) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop_ok)
        r_rptr <= r_rptr + 1'b1;
      case (w_op)
        FIFO_PUSH: r_count <= r_count + 1'b1;
        FIFO_POP:  r_count <= r_count - 1'b1;
        default:   r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sipo_deser_8bit.sv
// Serial-in, MSB-first word deserializer feeding a small output buffer with sticky overrun.
module sipo_deser_8bit
  import piso_regs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             realign,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitcnt;
  logic             r_overrun;
  logic [WIDTH-1:0] w_base_shift;
  logic [CW-1:0]    w_base_cnt;
  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [AW:0]      w_count;

  // Realign behaves as if the partial word were already empty when this edge's bit lands.
  assign w_base_shift = realign ? '0 : r_shift;
  assign w_base_cnt   = realign ? '0 : r_bitcnt;
  assign w_word       = {w_base_shift[WIDTH-2:0], sin};
  assign w_last       = sin_en & (w_base_cnt == CW'(WIDTH-1));
  assign w_pop        = out_valid & out_ready;
  assign w_drop       = w_last & w_full & ~w_pop;

  assign out_valid = ~w_empty;
  assign overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (sin_en) begin
      r_shift  <= w_word;
      r_bitcnt <= w_last ? '0 : w_base_cnt + 1'b1;
    end else if (realign) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_overrun <= 1'b0;
    else if (w_drop)
      r_overrun <= 1'b1;
    else if (ovr_clr)
      r_overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_last),
    .pop   (w_pop),
    .din   (w_word),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  a_count_bound: assert property (@(posedge clk) w_count <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_sipo_deser_8bit.sv
// Directed bench: a vector table for single-word flows plus hand sequences for buffering corners.
module tb_sipo_deser_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic       realign = 1'b0;
  logic       out_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overrun;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    logic       rst, sin, en, rl, rdy, clr;
    logic       ev, eo;
    logic [7:0] ed;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sipo_deser_8bit #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .realign   (realign),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step(input logic r, s, e, a, y, c);
    rst = r; sin = s; sin_en = e; realign = a; out_ready = y; ovr_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last,
                           input logic clr_last);
    for (int i = 7; i >= 0; i--)
      step(1'b0, w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_body, (i == 0) ? clr_last : 1'b0);
  endtask

  function automatic void add(input string nm, input logic r, s, e, rl, rdy, clr,
                              input logic ev, input logic [7:0] ed, input logic eo);
    vec_t v;
    v.nm = nm; v.rst = r; v.sin = s; v.en = e; v.rl = rl; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] w;

    // Basic word A9 with consumer ready: valid one cycle after the 8th bit, popped next edge.
    add("rst", 1, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    w = 8'hA9;
    for (int i = 7; i >= 0; i--) add("a9_bit", 0, w[i], 1, 0, 1, 0, (i == 0), 8'hA9, 0);
    add("a9_pop", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);

    // Word 5A with enable gaps; sin toggles during gaps and must be ignored.
    w = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      add("5a_bit", 0, w[i], 1, 0, 0, 0, (i == 0), 8'h5A, 0);
      if (i != 0) add("5a_gap", 0, ~w[i], 0, 0, 0, 0, 0, 8'h00, 0);
    end
    add("5a_hold", 0, 0, 0, 0, 0, 0, 1, 8'h5A, 0);
    add("5a_hold", 0, 1, 0, 0, 0, 0, 1, 8'h5A, 0);
    add("5a_pop", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);

    // Realign mid-word with a coincident enabled bit that becomes the new MSB.
    for (int i = 0; i < 3; i++) add("rl_pre", 0, 1, 1, 0, 1, 0, 0, 8'h00, 0);
    add("rl_edge", 0, 0, 1, 1, 1, 0, 0, 8'h00, 0);
    w = 8'h07;
    for (int i = 6; i >= 0; i--) add("rl_bit", 0, w[i], 1, 0, 1, 0, (i == 0), 8'h07, 0);
    add("rl_pop", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].sin, tbl[k].en, tbl[k].rl, tbl[k].rdy, tbl[k].clr);
      chk($sformatf("%s[%0d].valid", tbl[k].nm, k), out_valid, tbl[k].ev);
      chk($sformatf("%s[%0d].ovr", tbl[k].nm, k), overrun, tbl[k].eo);
      if (tbl[k].ev) chk($sformatf("%s[%0d].data", tbl[k].nm, k), out_data, tbl[k].ed);
      if (tbl[k].rst) chk($sformatf("%s[%0d].data0", tbl[k].nm, k), out_data, 8'h00);
    end

    // Overrun: two words buffered, third dropped; drain in order.
    send_word(8'hA9, 0, 0, 0);
    chk("ovr_w1_valid", out_valid, 1);
    chk("ovr_w1_data", out_data, 8'hA9);
    send_word(8'h3C, 0, 0, 0);
    chk("ovr_w2_ovr", overrun, 0);
    send_word(8'hFF, 0, 0, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_head", out_data, 8'hA9);
    step(0, 0, 0, 0, 1, 0);
    chk("ovr_pop1_valid", out_valid, 1);
    chk("ovr_pop1_data", out_data, 8'h3C);
    step(0, 0, 0, 0, 1, 0);
    chk("ovr_pop2_valid", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", overrun, 0);

    // Clear coinciding with a fresh drop leaves the flag set.
    send_word(8'h11, 0, 0, 0);
    send_word(8'h22, 0, 0, 0);
    send_word(8'h33, 0, 0, 1);
    chk("ovr_clr_vs_set", overrun, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_clr2", overrun, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("drain_valid", out_valid, 0);

    // Push and pop on the same edge at full: no overrun, order preserved.
    send_word(8'h11, 0, 0, 0);
    send_word(8'h22, 0, 0, 0);
    send_word(8'h33, 0, 1, 0);
    chk("swap_ovr", overrun, 0);
    chk("swap_valid", out_valid, 1);
    chk("swap_head", out_data, 8'h22);
    step(0, 1, 0, 0, 0, 0);
    chk("swap_stall", out_data, 8'h22);
    step(0, 0, 0, 0, 1, 0);
    chk("swap_next_valid", out_valid, 1);
    chk("swap_next", out_data, 8'h33);
    step(0, 0, 0, 0, 1, 0);
    chk("swap_empty", out_valid, 0);

    // Reset with buffered words, overrun set and a partial word pending.
    send_word(8'h44, 0, 0, 0);
    send_word(8'h55, 0, 0, 0);
    send_word(8'h66, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_data", out_data, 8'h00);
    send_word(8'hC3, 0, 0, 0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'hC3);
    step(0, 0, 0, 0, 1, 0);
    chk("post_rst_empty", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
